piso_tx_ctrl: RTL and testbench
===============================

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 SHALL have parameter P_WIDTH, default 4, meaning parallel word width in bits (legal: >= 2).
REQ-002 SHALL have parameter P_BIT_CYCLES, default 1, meaning clock cycles each serial bit is held (legal: >= 1).
REQ-003 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  input  1  requester has a word on i_data.
REQ-006 SHALL have port o_ready  output  1  controller can accept a word.
REQ-007 SHALL have port i_data  input  P_WIDTH  parallel word to serialise.
REQ-008 SHALL have port o_serial_out  output  1  serial line, MSB first.
REQ-009 SHALL have port o_frame  output  1  high while o_serial_out carries a frame bit.
REQ-010 SHALL have port o_done  output  1  single-cycle pulse after last frame bit.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PARITY (macro-dependent), DONE.
REQ-012 SHALL assert o_ready only in IDLE; transfer occurs on a rising edge where i_valid and o_ready are both high.
REQ-013 SHALL, on transfer, capture i_data into the shift register and move IDLE->SHIFT on the same edge.
REQ-014 SHALL drive bit P_WIDTH-1 on o_serial_out from the cycle after transfer (latency 1 cycle); each bit is held exactly P_BIT_CYCLES cycles, then the next lower bit.
REQ-015 SHALL hold o_frame high for all SHIFT/PARITY cycles and low otherwise.
REQ-016 SHALL move SHIFT->DONE (or SHIFT->PARITY when enabled) after the LSB's final hold cycle; DONE lasts exactly 1 cycle with o_done=1, then DONE->IDLE.
REQ-017 SHALL drive o_serial_out=0 outside SHIFT/PARITY.
REQ-018 SHALL ignore i_data and i_valid outside IDLE; changes mid-frame never affect the frame in progress.
REQ-019 SHALL give back-to-back throughput of one word per P_WIDTH*P_BIT_CYCLES+2 cycles (+P_BIT_CYCLES with parity) when i_valid is held high.
REQ-020 SHALL size the bit counter as $clog2(P_WIDTH+1) and the hold counter as max(1,$clog2(P_BIT_CYCLES)); neither wraps within a frame.
REQ-021 SHALL, with P_BIT_CYCLES=1, advance one bit per cycle with no idle cycles inside the frame.

Reset
REQ-022 SHALL, while i_rst=0, force state IDLE, o_ready=1, o_serial_out=0, o_frame=0, o_done=0, counters and shift register 0, asynchronously.
REQ-023 SHALL abort any frame in progress on reset assertion; no o_done pulse is produced for an aborted frame.
REQ-024 SHALL accept a word on the first rising edge after i_rst deasserts if i_valid=1.

Configuration
REQ-025 SHALL use macro PISO_PARITY_EN: when defined, an even-parity bit (XOR of the captured word) follows the LSB in state PARITY, held P_BIT_CYCLES cycles with o_frame=1.
REQ-026 SHALL, when PISO_PARITY_EN is undefined, omit state PARITY and its logic entirely; SHIFT goes directly to DONE.

Structure
REQ-027 SHALL place the state enum typedef and default parameter constants in shared package piso_pkg.
REQ-028 SHALL implement the shift register (load, shift-enable, MSB output) as sub-module piso_shifter; the FSM and counters stay in piso_tx_ctrl.

Verification
REQ-029 SHALL cover: W=4,B=1, i_data=4'b1010 accepted at cycle 0 -> o_serial_out 1,0,1,0 at cycles 1-4, o_frame=1 cycles 1-4, o_done=1 at cycle 5, o_ready=1 at cycle 6.
REQ-030 SHALL cover: W=4,B=3, i_data=4'b1100 -> each bit held 3 cycles (1,1,1,1,1,1,0,0,0,0,0,0), o_done at cycle 13.
REQ-031 SHALL cover: PISO_PARITY_EN, W=4,B=1, i_data=4'b1011 -> bits 1,0,1,1 then parity 1 at cycle 5, o_done at cycle 6.
REQ-032 SHALL cover: i_rst pulsed low after 2 bits of 4'b1010 -> outputs at reset values immediately, no o_done, new word accepted on first edge after release.
REQ-033 SHALL cover: i_valid held high with 4'b1010 then 4'b0110, and i_data toggled mid-frame -> accepts exactly 6 cycles apart (W=4,B=1), serial stream 1010 then 0110 unaffected by mid-frame toggles.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: state encoding, default parameters and counter sizing shared by the PISO transmitter.
// Macro PISO_PARITY_EN adds the PARITY state.
package piso_pkg;
    localparam int DEF_WIDTH      = 4;
    localparam int DEF_BIT_CYCLES = 1;
`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    function automatic int hold_bits(input int cycles);
        return cycles > 1 ? $clog2(cycles) : 1;
    endfunction
endpackage

// File: rtl/piso_tx_ctrl_if.sv
// piso_tx_ctrl_if: valid/ready word handshake plus serial frame outputs of the PISO transmitter.
interface piso_tx_ctrl_if import piso_pkg::*; #(parameter int P_WIDTH = DEF_WIDTH);
    logic               i_valid;
    logic               o_ready;
    logic [P_WIDTH-1:0] i_data;
    logic               o_serial_out;
    logic               o_frame;
    logic               o_done;
    modport master (output i_valid, i_data, input o_ready, o_serial_out, o_frame, o_done);
    modport slave  (input i_valid, i_data, output o_ready, o_serial_out, o_frame, o_done);
endinterface

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-load left shift register presenting its MSB.
module piso_shifter import piso_pkg::*; #(
    parameter int P_WIDTH = DEF_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [P_WIDTH-1:0] i_data,
    output logic               o_msb
);
    logic [P_WIDTH-1:0] sr_q, sr_d;
    always_comb sr_d = i_load ? i_data : i_shift ? {sr_q[P_WIDTH-2:0], 1'b0} : sr_q;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) sr_q <= '0;
        else        sr_q <= sr_d;
    end
    assign o_msb = sr_q[P_WIDTH-1];
endmodule

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: accepts a word on valid/ready and sends it MSB first, each bit held P_BIT_CYCLES.
// Macro PISO_PARITY_EN appends an even-parity bit after the LSB.
module piso_tx_ctrl import piso_pkg::*; #(
    parameter int P_WIDTH      = DEF_WIDTH,
    parameter int P_BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic          i_clk,
    input  logic          i_rst,
    piso_tx_ctrl_if.slave bus
);
    localparam int BW = $clog2(P_WIDTH + 1);
    localparam int HW = hold_bits(P_BIT_CYCLES);
    localparam logic [BW-1:0] LAST_BIT  = BW'(P_WIDTH - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(P_BIT_CYCLES - 1);
    state_t        state_q;
    logic [BW-1:0] bit_q;
    logic [HW-1:0] hold_q;
    logic          ready_q, frame_q, done_q, msb, take, hold_end, shift;
    assign take     = state_q == IDLE && bus.i_valid;
    assign hold_end = hold_q == LAST_HOLD;
    assign shift    = state_q == SHIFT && hold_end && bit_q != '0;
    piso_shifter #(.P_WIDTH(P_WIDTH)) u_shifter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (take),
        .i_shift(shift),
        .i_data (bus.i_data),
        .o_msb  (msb)
    );
`ifdef PISO_PARITY_EN
    logic par_q;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)    par_q <= 1'b0;
        else if (take) par_q <= ^bus.i_data;
    end
    assign bus.o_serial_out = frame_q & (state_q == PARITY ? par_q : msb);
`else
    assign bus.o_serial_out = frame_q & msb;
`endif
    // bit_q counts bits still to send after the current one; hold_q counts cycles within a bit
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            hold_q  <= '0;
            ready_q <= 1'b1;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.i_valid) begin
                    state_q <= SHIFT;
                    bit_q   <= LAST_BIT;
                    hold_q  <= '0;
                    ready_q <= 1'b0;
                    frame_q <= 1'b1;
                end
                SHIFT: if (!hold_end) hold_q <= hold_q + 1'b1;
                else begin
                    hold_q <= '0;
                    if (bit_q != '0) bit_q <= bit_q - 1'b1;
                    else begin
`ifdef PISO_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= DONE;
                        frame_q <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: if (!hold_end) hold_q <= hold_q + 1'b1;
                else begin
                    hold_q  <= '0;
                    state_q <= DONE;
                    frame_q <= 1'b0;
                    done_q  <= 1'b1;
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.o_ready = ready_q;
    assign bus.o_frame = frame_q;
    assign bus.o_done  = done_q;
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: directed, table-driven bench for W=4 with B=1 and B=3 instances.
// Outputs are compared as {ready, serial, frame, done}; parity expectations follow PISO_PARITY_EN.
module tb_piso_tx_ctrl;
    import piso_pkg::*;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    typedef struct {
        logic [3:0] d;
        logic [3:0] bits;
        logic       par;
    } word_t;
    typedef struct {
        logic       v;
        logic [3:0] d;
        logic [3:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    always #5 clk = ~clk;

    piso_tx_ctrl_if #(.P_WIDTH(4)) b1 ();
    piso_tx_ctrl_if #(.P_WIDTH(4)) b3 ();
    piso_tx_ctrl #(.P_WIDTH(4), .P_BIT_CYCLES(1)) dut1 (.i_clk(clk), .i_rst(rst_n), .bus(b1));
    piso_tx_ctrl #(.P_WIDTH(4), .P_BIT_CYCLES(3)) dut3 (.i_clk(clk), .i_rst(rst_n), .bus(b3));

    function automatic logic [3:0] outs(input int w);
        return w == 3 ? {b3.o_ready, b3.o_serial_out, b3.o_frame, b3.o_done}
                      : {b1.o_ready, b1.o_serial_out, b1.o_frame, b1.o_done};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: {rdy,ser,frm,done} got %b expected %b", name, act, exp);
    endtask

    task automatic drive(input int w, input logic v, input logic [3:0] d);
        if (w == 3) begin b3.i_valid = v; b3.i_data = d; end
        else begin b1.i_valid = v; b1.i_data = d; end
    endtask

    // Called in an IDLE cycle; the transfer happens on the next rising edge.
    task automatic run_frame(input int w, input word_t t, input string tag);
        int bc = w == 3 ? 3 : 1;
        int np = PAR ? bc : 0;
        drive(w, 1'b1, t.d);
        check({tag, " accept"}, outs(w), 4'b1000);
        @(posedge clk);
        #1 drive(w, 1'b0, ~t.d);
        for (int k = 0; k < 4; k++)
            for (int h = 0; h < bc; h++) begin
                @(negedge clk);
                check($sformatf("%s bit%0d hold%0d", tag, k, h), outs(w), {1'b0, t.bits[3-k], 2'b10});
            end
        for (int h = 0; h < np; h++) begin
            @(negedge clk);
            check($sformatf("%s parity hold%0d", tag, h), outs(w), {1'b0, t.par, 2'b10});
        end
        @(negedge clk);
        check({tag, " done"}, outs(w), 4'b0001);
        @(negedge clk);
        check({tag, " idle"}, outs(w), 4'b1000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        word_t words[$];
        cyc_t  b2b[$];
        words.push_back('{4'b1010, 4'b1010, 1'b0});
        words.push_back('{4'b1011, 4'b1011, 1'b1});
        words.push_back('{4'b0001, 4'b0001, 1'b1});
        words.push_back('{4'b1111, 4'b1111, 1'b0});
        words.push_back('{4'b0000, 4'b0000, 1'b0});
        words.push_back('{4'b0110, 4'b0110, 1'b0});
`ifdef PISO_PARITY_EN
        b2b = '{'{1, 4'b1010, 4'b1000}, '{1, 4'b1111, 4'b0110}, '{1, 4'b0000, 4'b0010},
                '{1, 4'b0101, 4'b0110}, '{1, 4'b1001, 4'b0010}, '{1, 4'b0011, 4'b0010},
                '{1, 4'b1110, 4'b0001}, '{1, 4'b0110, 4'b1000}, '{1, 4'b0001, 4'b0010},
                '{1, 4'b1000, 4'b0110}, '{1, 4'b1111, 4'b0110}, '{1, 4'b0000, 4'b0010},
                '{1, 4'b1010, 4'b0010}, '{1, 4'b0101, 4'b0001}, '{0, 4'b0000, 4'b1000}};
`else
        b2b = '{'{1, 4'b1010, 4'b1000}, '{1, 4'b1111, 4'b0110}, '{1, 4'b0000, 4'b0010},
                '{1, 4'b0101, 4'b0110}, '{1, 4'b1001, 4'b0010}, '{1, 4'b1110, 4'b0001},
                '{1, 4'b0110, 4'b1000}, '{1, 4'b0001, 4'b0010}, '{1, 4'b1000, 4'b0110},
                '{1, 4'b1111, 4'b0110}, '{1, 4'b0000, 4'b0010}, '{1, 4'b1010, 4'b0001},
                '{0, 4'b0000, 4'b1000}};
`endif
        drive(1, 1'b0, 4'b0000);
        drive(3, 1'b0, 4'b0000);
        #12;
        check("reset B1", outs(1), 4'b1000);
        check("reset B3", outs(3), 4'b1000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (words[i]) run_frame(1, words[i], $sformatf("B1 word%0d", i));
        run_frame(3, '{4'b1100, 4'b1100, 1'b0}, "B3 1100");

        // Abort after two bits of 1010; the next word waits on i_data through reset.
        drive(1, 1'b1, 4'b1010);
        check("abort accept", outs(1), 4'b1000);
        @(posedge clk);
        #1 drive(1, 1'b1, 4'b0110);
        @(negedge clk);
        check("abort bit0", outs(1), 4'b0110);
        @(negedge clk);
        check("abort bit1", outs(1), 4'b0010);
        #1 rst_n = 1'b0;
        #1 check("abort async reset", outs(1), 4'b1000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort held%0d", k), outs(1), 4'b1000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(1, '{4'b0110, 4'b0110, 1'b0}, "post-reset");

        foreach (b2b[k]) begin
            if (k > 0) @(negedge clk);
            drive(1, b2b[k].v, b2b[k].d);
            check($sformatf("b2b cycle%0d", k), outs(1), b2b[k].exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
